// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer and its stack_memory consumers.
package stack_pkg;
    localparam logic [2:0] OP_PUSH   = 3'd0;
    localparam logic [2:0] OP_POP    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_SETESP = 3'd4;

    localparam logic [3:0] RW_IDLE  = 4'h0;
    localparam logic [3:0] RW_PUSH  = 4'h1;
    localparam logic [3:0] RW_STORE = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREP   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Request fields kept for the lifetime of one operation
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
        logic        err;
    } req_t;
endpackage

// File: rtl/stack_bounds_check.sv
// Combinational legality check for a request against the current ESP and stack window.
module stack_bounds_check
    import stack_pkg::*;
#(
    parameter logic [31:0] STACK_TOP   = 32'd512,
    parameter logic [31:0] STACK_LIMIT = 32'd0
) (
    input  logic [2:0]  op,
    input  logic [31:0] esp,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        err
);
    // One extra bit so that +4 / -4 around the window edges cannot wrap
    localparam logic [32:0] TOP_X = {1'b0, STACK_TOP};
    localparam logic [32:0] LIM_X = {1'b0, STACK_LIMIT};

    logic [32:0] esp_x, addr_x, data_x;

    assign esp_x  = {1'b0, esp};
    assign addr_x = {1'b0, addr};
    assign data_x = {1'b0, data};

    always_comb begin
        err = 1'b0;
        case (op)
            OP_PUSH:          err = esp_x < (LIM_X + 33'd4);
            OP_POP:           err = (esp_x + 33'd4) > TOP_X;
            OP_LOAD, OP_STORE: err = (addr_x < LIM_X) || ((addr_x + 33'd4) > TOP_X);
            OP_SETESP:        err = (data[1:0] != 2'b00) || (data_x < LIM_X) || (data_x > TOP_X);
            default:          err = 1'b1;
        endcase
    end
endmodule

// File: rtl/stack_controller.sv
// ESP owner and request sequencer in front of stack_memory: fixed
// IDLE/PREP/ACCESS/RESP walk per request, one response per accepted request.
module stack_controller
    import stack_pkg::*;
#(
    parameter logic [31:0] STACK_TOP   = 32'd512,
    parameter logic [31:0] STACK_LIMIT = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic [31:0] esp,
    output logic [31:0] stack_addr,
    output logic [3:0]  read_or_write,
    output logic [31:0] write_data,
    input  logic [31:0] stack_esp,
    input  logic [31:0] stack_addr_access
);
    state_e state, state_nxt;
    req_t   cur;
    logic   acc_err;

    stack_bounds_check #(
        .STACK_TOP  (STACK_TOP),
        .STACK_LIMIT(STACK_LIMIT)
    ) u_bounds (
        .op  (req_op),
        .esp (esp),
        .addr(req_addr),
        .data(req_data),
        .err (acc_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = ST_PREP;
            ST_PREP:   state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobe decoded from state so an async reset drops it in the same instant
    always_comb begin
        req_ready     = (state == ST_IDLE);
        rsp_valid     = (state == ST_RESP);
        read_or_write = RW_IDLE;
        if (state == ST_ACCESS && !cur.err) begin
            case (cur.op)
                OP_PUSH:  read_or_write = RW_PUSH;
                OP_STORE: read_or_write = RW_STORE;
                default:  read_or_write = RW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur        <= '0;
            esp        <= STACK_TOP;
            stack_addr <= '0;
            write_data <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cur        <= '{op: req_op, data: req_data, err: acc_err};
                        write_data <= req_data;
                        stack_addr <= req_addr;
                        rsp_data   <= '0;
                        rsp_error  <= 1'b0;
                    end
                end
                ST_PREP: begin
                    if (!cur.err && cur.op == OP_PUSH) esp <= esp - 32'd4;
                end
                ST_ACCESS: begin
                    rsp_error <= cur.err;
                    if (!cur.err) begin
                        case (cur.op)
                            OP_POP: begin
                                rsp_data <= stack_esp;
                                esp      <= esp + 32'd4;
                            end
                            OP_LOAD:   rsp_data <= stack_addr_access;
                            OP_SETESP: esp      <= cur.data;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
